instr_mem_arbiter: RTL and testbench

//  Two-master arbiter between the per-core instruction caches and the single

---
 rtl/instr_arb_pkg.sv | 11 +
 rtl/arb_id_fifo.sv | 54 +++++
 rtl/instr_mem_arbiter.sv | 95 +++++++++
 tb/tb_instr_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package instr_arb_pkg;

  typedef logic mid_t;

  localparam mid_t MID_CORE0 = 1'b0;
  localparam mid_t MID_CORE1 = 1'b1;

  localparam int OUTSTANDING_DEF = 2;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of master IDs for memory requests that are accepted but not yet answered.
module arb_id_fifo
  import instr_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       din,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mid_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= MID_CORE0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= ptr_next(wptr);
      end
      if (pop_ok) rptr <= ptr_next(rptr);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Two-core instruction-cache arbiter onto one main-memory port, with in-order
// response routing via an ID FIFO and a sticky protocol-error flag.
module instr_mem_arbiter
  import instr_arb_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        c0_req,
  input  logic [31:0] c0_adr,
  output logic        c0_gnt,
  output logic        c0_rvalid,
  output logic [31:0] c0_read,
  input  logic        c1_req,
  input  logic [31:0] c1_adr,
  output logic        c1_gnt,
  output logic        c1_rvalid,
  output logic [31:0] c1_read,
  output logic        instr_req,
  output logic [31:0] instr_adr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_read,
  output logic        arb_err
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  logic             lock;
  mid_t             locked_id;
  mid_t             last_grant;
  mid_t             sel;
  mid_t             head_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             has_room;
  logic             accept;
  logic             resp_ok;

  // A pending un-granted request pins the selection so the address never switches masters.
  always_comb begin
    sel = MID_CORE0;
    if (lock)                  sel = locked_id;
    else if (c0_req && c1_req) sel = ~last_grant;
    else if (c1_req)           sel = MID_CORE1;
  end

  assign has_room  = !fifo_full && (fifo_count < CNT_W'(OUTSTANDING));
  assign instr_req = !res && (c0_req || c1_req) && has_room;
  assign instr_adr = !instr_req ? 32'h0 : ((sel == MID_CORE1) ? c1_adr : c0_adr);
  assign accept    = instr_req && instr_gnt;
  assign c0_gnt    = accept && (sel == MID_CORE0);
  assign c1_gnt    = accept && (sel == MID_CORE1);

  assign resp_ok   = !res && instr_rvalid && !fifo_empty;
  assign c0_rvalid = resp_ok && (head_id == MID_CORE0);
  assign c1_rvalid = resp_ok && (head_id == MID_CORE1);
  assign c0_read   = c0_rvalid ? instr_read : 32'h0;
  assign c1_read   = c1_rvalid ? instr_read : 32'h0;

  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .res   (res),
    .push  (accept),
    .pop   (resp_ok),
    .din   (sel),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lock       <= 1'b0;
      locked_id  <= MID_CORE0;
      last_grant <= MID_CORE1;
      arb_err    <= 1'b0;
    end else begin
      if (accept) begin
        lock       <= 1'b0;
        last_grant <= sel;
      end else if (instr_req) begin
        lock      <= 1'b1;
        locked_id <= sel;
      end
      if (instr_rvalid && fifo_empty) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: directed vector table, reset corner sequence,
// and randomized traffic against a queue-based reference model.
module tb_instr_mem_arbiter;

  localparam int OUTS = 2;

  logic        clk;
  logic        res;
  logic        c0_req, c1_req;
  logic [31:0] c0_adr, c1_adr;
  logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [31:0] c0_read, c1_read;
  logic        instr_req, instr_gnt, instr_rvalid;
  logic [31:0] instr_adr, instr_read;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  instr_mem_arbiter #(.OUTSTANDING(OUTS)) dut (
    .clk          (clk),
    .res          (res),
    .c0_req       (c0_req),
    .c0_adr       (c0_adr),
    .c0_gnt       (c0_gnt),
    .c0_rvalid    (c0_rvalid),
    .c0_read      (c0_read),
    .c1_req       (c1_req),
    .c1_adr       (c1_adr),
    .c1_gnt       (c1_gnt),
    .c1_rvalid    (c1_rvalid),
    .c1_read      (c1_read),
    .instr_req    (instr_req),
    .instr_adr    (instr_adr),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_read   (instr_read),
    .arb_err      (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          first;
    bit          c0r;
    logic [31:0] c0a;
    bit          c1r;
    logic [31:0] c1a;
    bit          g;
    bit          rv;
    logic [31:0] rd;
    logic [101:0] exp_v;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit first, bit c0r, logic [31:0] c0a, bit c1r, logic [31:0] c1a,
                              bit g, bit rv, logic [31:0] rd,
                              bit e_req, logic [31:0] e_adr, bit e_g0, bit e_g1,
                              bit e_rv0, bit e_rv1, logic [31:0] e_rd0, logic [31:0] e_rd1,
                              bit e_err);
    vec_t v;
    v.first = first; v.c0r = c0r; v.c0a = c0a; v.c1r = c1r; v.c1a = c1a;
    v.g = g; v.rv = rv; v.rd = rd;
    v.exp_v = {e_req, e_adr, e_g0, e_g1, e_rv0, e_rv1, e_rd0, e_rd1, e_err};
    return v;
  endfunction

  // Outputs packed as {instr_req, instr_adr, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_read, c1_read, arb_err}
  task automatic check(input string name, input logic [101:0] exp_v);
    logic [101:0] act;
    act = {instr_req, instr_adr, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_read, c1_read, arb_err};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic zero_inputs();
    c0_req = 0; c0_adr = 0; c1_req = 0; c1_adr = 0;
    instr_gnt = 0; instr_rvalid = 0; instr_read = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    zero_inputs();
    #2;
    res = 1'b0;
  endtask

  // Reference model: queue of owners of outstanding requests, plus arbitration history.
  bit m_q[$];
  bit m_last;
  bit m_locked;
  bit m_lock_id;
  bit m_err;

  task automatic model_reset();
    m_q.delete();
    m_last = 1'b1;
    m_locked = 1'b0;
    m_lock_id = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_eval(output logic [101:0] exp_v, output bit acc, output bit req, output bit sel);
    bit g0, g1, rv0, rv1;
    logic [31:0] adr, rd0, rd1;
    req = (c0_req || c1_req) && (m_q.size() < OUTS);
    if (m_locked)              sel = m_lock_id;
    else if (c0_req && c1_req) sel = !m_last;
    else                       sel = c1_req;
    adr = req ? (sel ? c1_adr : c0_adr) : 32'h0;
    acc = req && instr_gnt;
    g0 = acc && !sel;
    g1 = acc && sel;
    rv0 = 0; rv1 = 0;
    if (instr_rvalid && m_q.size() > 0) begin
      if (m_q[0]) rv1 = 1; else rv0 = 1;
    end
    rd0 = rv0 ? instr_read : 32'h0;
    rd1 = rv1 ? instr_read : 32'h0;
    exp_v = {req, adr, g0, g1, rv0, rv1, rd0, rd1, m_err};
  endtask

  task automatic model_step(input bit acc, input bit req, input bit sel);
    if (instr_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (acc) begin
      m_q.push_back(sel);
      m_last = sel;
      m_locked = 1'b0;
    end else if (req) begin
      m_locked = 1'b1;
      m_lock_id = sel;
    end
  endtask

  initial begin
    logic [101:0] ev;
    bit acc, req, sel, done0, done1;

    res = 1'b1;
    zero_inputs();
    #12;
    res = 1'b0;

    // first, c0r,c0a, c1r,c1a, g,rv,rd | req,adr, g0,g1, rv0,rv1, rd0,rd1, err
    tbl.push_back(mk(1, 1,'h100, 0,0,     1,0,0,            1,'h100, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     1,0,0,            0,0,     0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'hDEADBEEF,   0,0,     0,0, 1,0, 'hDEADBEEF,0, 0));
    tbl.push_back(mk(1, 1,'h200, 1,'h300, 1,0,0,            1,'h200, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     1,'h300, 1,0,0,            1,'h300, 0,1, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     1,1,'hA0A0A0A0,   0,0,     0,0, 1,0, 'hA0A0A0A0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     1,1,'hB1B1B1B1,   0,0,     0,0, 0,1, 0,'hB1B1B1B1, 0));
    tbl.push_back(mk(1, 1,'h200, 0,0,     0,0,0,            1,'h200, 0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h200, 1,'h300, 0,0,0,            1,'h200, 0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h200, 1,'h300, 0,0,0,            1,'h200, 0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h200, 1,'h300, 1,0,0,            1,'h200, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     1,'h300, 1,0,0,            1,'h300, 0,1, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'h11111111,   0,0,     0,0, 1,0, 'h11111111,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'h22222222,   0,0,     0,0, 0,1, 0,'h22222222, 0));
    tbl.push_back(mk(1, 1,'h400, 1,'h500, 1,0,0,            1,'h400, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h404, 1,'h500, 1,0,0,            1,'h500, 0,1, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h404, 0,0,     1,0,0,            0,0,     0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,'h404, 0,0,     1,1,'h33333333,   0,0,     0,0, 1,0, 'h33333333,0, 0));
    tbl.push_back(mk(0, 1,'h404, 0,0,     1,0,0,            1,'h404, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'h44444444,   0,0,     0,0, 0,1, 0,'h44444444, 0));
    tbl.push_back(mk(0, 0,0,     1,'h600, 1,1,'h55555555,   1,'h600, 0,1, 1,0, 'h55555555,0, 0));
    tbl.push_back(mk(0, 1,'h700, 1,'h604, 1,0,0,            1,'h700, 1,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     1,'h604, 1,0,0,            0,0,     0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     1,'h604, 0,1,'h66666666,   0,0,     0,0, 0,1, 0,'h66666666, 0));
    tbl.push_back(mk(0, 0,0,     1,'h604, 1,1,'h77777777,   1,'h604, 0,1, 1,0, 'h77777777,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'h88888888,   0,0,     0,0, 0,1, 0,'h88888888, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,1,'h99999999,   0,0,     0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 0,0,     0,0,     0,0,0,            0,0,     0,0, 0,0, 0,0, 1));
    tbl.push_back(mk(0, 0,0,     0,0,     0,0,0,            0,0,     0,0, 0,0, 0,0, 1));

    foreach (tbl[i]) begin
      if (tbl[i].first) do_reset();
      @(negedge clk);
      c0_req = tbl[i].c0r; c0_adr = tbl[i].c0a;
      c1_req = tbl[i].c1r; c1_adr = tbl[i].c1a;
      instr_gnt = tbl[i].g; instr_rvalid = tbl[i].rv; instr_read = tbl[i].rd;
      #1;
      check($sformatf("row%0d", i), tbl[i].exp_v);
    end

    // Async reset with a transaction in flight: outputs drop at once, old ID is discarded.
    @(negedge clk);
    c0_req = 1; c0_adr = 32'h800; c1_req = 0; c1_adr = 0;
    instr_gnt = 1; instr_rvalid = 0; instr_read = 0;
    #1;
    check("pre_reset_grant", {1'b1, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1});
    @(negedge clk);
    c0_adr = 32'h804; instr_gnt = 0;
    #1;
    res = 1'b1;
    #1;
    check("reset_outputs_zero", 102'h0);
    c0_req = 0; c0_adr = 0;
    #1;
    res = 1'b0;
    @(negedge clk);
    instr_rvalid = 1; instr_read = 32'hAAAA5555;
    #1;
    check("stray_after_reset", 102'h0);
    @(negedge clk);
    instr_rvalid = 0; instr_read = 0;
    #1;
    check("err_after_stray", {101'h0, 1'b1});

    // Randomized traffic against the reference model, with periodic resets.
    done0 = 0; done1 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 250 == 0) begin
        do_reset();
        model_reset();
        done0 = 0; done1 = 0;
      end
      @(negedge clk);
      if (done0) c0_req = 0;
      if (done1) c1_req = 0;
      done0 = 0; done1 = 0;
      if (!c0_req && $urandom_range(0, 1) == 1) begin
        c0_req = 1; c0_adr = $urandom & 32'hFFFF_FFFC;
      end
      if (!c1_req && $urandom_range(0, 1) == 1) begin
        c1_req = 1; c1_adr = $urandom & 32'hFFFF_FFFC;
      end
      instr_gnt = ($urandom_range(0, 9) < 6);
      if (m_q.size() > 0) instr_rvalid = ($urandom_range(0, 1) == 1);
      else                instr_rvalid = ($urandom_range(0, 63) == 0);
      instr_read = $urandom;
      #1;
      model_eval(ev, acc, req, sel);
      check($sformatf("rand%0d", i), ev);
      model_step(acc, req, sel);
      if (acc && !sel) done0 = 1;
      if (acc && sel)  done1 = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
